// File: rtl/rv_pkg.sv
// Shared RV32 definitions for the instruction encoder: opcodes, formats and the stage-1 payload.
package rv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OPC_W = 7;
    localparam int unsigned REG_W = 5;
    localparam int unsigned F3_W  = 3;
    localparam int unsigned F7_W  = 7;
    localparam int unsigned IMM_W = 21;

    localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OP_IMM    = 7'b0010011;
    localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OP_REG    = 7'b0110011;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

    // Only the low 21 immediate bits ever reach the instruction word.
    typedef struct packed {
        fmt_e             fmt;
        logic [OPC_W-1:0] opcode;
        logic [REG_W-1:0] rd;
        logic [F3_W-1:0]  funct3;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [F7_W-1:0]  funct7;
        logic [IMM_W-1:0] imm;
        logic             err;
    } enc_req_t;

    function automatic fmt_e fmt_of(input logic [OPC_W-1:0] op);
        fmt_e f;
        case (op)
            OP_LOAD, OP_IMM, OP_JALR: f = FMT_I;
            OP_STORE:                 f = FMT_S;
            OP_BRANCH:                f = FMT_B;
            OP_LUI, OP_AUIPC:         f = FMT_U;
            OP_JAL:                   f = FMT_J;
            default:                  f = FMT_R;
        endcase
        return f;
    endfunction

    function automatic logic opcode_known(input logic [OPC_W-1:0] op);
        logic k;
        case (op)
            OP_LOAD, OP_IMM, OP_JALR, OP_STORE, OP_BRANCH,
            OP_LUI, OP_AUIPC, OP_JAL, OP_REG: k = 1'b1;
            default:                          k = 1'b0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/imm_range_check.sv
// Checks whether a signed immediate is representable (and suitably aligned) in a given format.
module imm_range_check
    import rv_pkg::*;
(
    input  fmt_e              fmt,
    input  logic [XLEN-1:0]   imm_i,
    output logic              fits,
    output logic              aligned
);

    localparam int I_MIN = -2048;
    localparam int I_MAX = 2047;
    localparam int B_MIN = -4096;
    localparam int B_MAX = 4094;
    localparam int U_MIN = -524288;
    localparam int U_MAX = 524287;
    localparam int J_MIN = -1048576;
    localparam int J_MAX = 1048574;

    logic signed [XLEN-1:0] simm;
    assign simm = $signed(imm_i);

    always_comb begin
        fits    = 1'b1;
        aligned = 1'b1;
        case (fmt)
            FMT_I, FMT_S: fits = (simm >= I_MIN) && (simm <= I_MAX);
            FMT_B: begin
                fits    = (simm >= B_MIN) && (simm <= B_MAX);
                aligned = ~imm_i[0];
            end
            FMT_U: fits = (simm >= U_MIN) && (simm <= U_MAX);
            FMT_J: begin
                fits    = (simm >= J_MIN) && (simm <= J_MAX);
                aligned = ~imm_i[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// RV32 instruction encoder: packs fields and a signed immediate into a 32-bit word
// through a two-stage valid/ready pipeline (check/select, then output register).
module instr_encoder
    import rv_pkg::*;
#(
    parameter bit          CHECK_RANGE = 1'b1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [6:0]       opcode_i,
    input  logic [4:0]       rd_i,
    input  logic [2:0]       funct3_i,
    input  logic [4:0]       rs1_i,
    input  logic [4:0]       rs2_i,
    input  logic [6:0]       funct7_i,
    input  logic [31:0]      imm_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [31:0]      instr_o,
    output logic             err_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    fmt_e      req_fmt;
    logic      imm_fits;
    logic      imm_aligned;
    logic      req_err;
    enc_req_t  req_d;
    enc_req_t  s1_q;
    logic      s1_valid;
    logic      s2_ready;
    logic      s1_moves;
    logic [XLEN-1:0] word_d;

    assign req_fmt = fmt_of(opcode_i);

    imm_range_check u_range (
        .fmt     (req_fmt),
        .imm_i   (imm_i),
        .fits    (imm_fits),
        .aligned (imm_aligned)
    );

    // Unknown opcodes are always flagged; range problems only when checking is enabled.
    assign req_err = !opcode_known(opcode_i) || (CHECK_RANGE && !(imm_fits && imm_aligned));

    always_comb begin
        req_d = '{fmt:    req_fmt,
                  opcode: opcode_i,
                  rd:     rd_i,
                  funct3: funct3_i,
                  rs1:    rs1_i,
                  rs2:    rs2_i,
                  funct7: funct7_i,
                  imm:    imm_i[IMM_W-1:0],
                  err:    req_err};
    end

    assign s2_ready = !valid_o || ready_i;
    assign s1_moves = s1_valid && s2_ready;
    assign ready_o  = !s1_valid || s1_moves;

    // Stage 1: capture request fields, format and error.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (ready_o) begin
            s1_valid <= valid_i;
            if (valid_i) begin
                s1_q <= req_d;
            end
        end
    end

    // Scatter immediate bits according to the captured format.
    always_comb begin
        word_d = '0;
        case (s1_q.fmt)
            FMT_I: word_d = {s1_q.imm[11:0], s1_q.rs1, s1_q.funct3, s1_q.rd, s1_q.opcode};
            FMT_S: word_d = {s1_q.imm[11:5], s1_q.rs2, s1_q.rs1, s1_q.funct3,
                             s1_q.imm[4:0], s1_q.opcode};
            FMT_B: word_d = {s1_q.imm[12], s1_q.imm[10:5], s1_q.rs2, s1_q.rs1, s1_q.funct3,
                             s1_q.imm[4:1], s1_q.imm[11], s1_q.opcode};
            FMT_U: word_d = {s1_q.imm[19:0], s1_q.rd, s1_q.opcode};
            FMT_J: word_d = {s1_q.imm[20], s1_q.imm[10:1], s1_q.imm[11], s1_q.imm[19:12],
                             s1_q.rd, s1_q.opcode};
            default: word_d = {s1_q.funct7, s1_q.rs2, s1_q.rs1, s1_q.funct3,
                               s1_q.rd, s1_q.opcode};
        endcase
    end

    // Stage 2: output register, held while downstream stalls.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o <= 1'b0;
            instr_o <= '0;
            err_o   <= 1'b0;
        end else if (s2_ready) begin
            valid_o <= s1_valid;
            if (s1_valid) begin
                instr_o <= word_d;
                err_o   <= s1_q.err;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_o <= '0;
        end else if (valid_o && ready_i && err_o && (err_cnt_o != '1)) begin
            err_cnt_o <= err_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: known encodings, range errors, back-pressure,
// counter saturation (second instance, CNT_W=2, no range check) and async reset.
module tb_instr_encoder;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic        ready_i;
    logic [6:0]  opcode_i;
    logic [4:0]  rd_i;
    logic [2:0]  funct3_i;
    logic [4:0]  rs1_i;
    logic [4:0]  rs2_i;
    logic [6:0]  funct7_i;
    logic [31:0] imm_i;

    logic        ready_o, valid_o, err_o;
    logic [31:0] instr_o;
    logic [15:0] err_cnt_o;
    logic        ready_s, valid_s, err_s;
    logic [31:0] instr_s;
    logic [1:0]  err_cnt_s;

    int total = 0;
    int bad   = 0;

    logic [31:0] w, w_s;
    logic        e, e_s;

    always #5 clk_i = ~clk_i;

    instr_encoder dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
        .opcode_i(opcode_i), .rd_i(rd_i), .funct3_i(funct3_i), .rs1_i(rs1_i),
        .rs2_i(rs2_i), .funct7_i(funct7_i), .imm_i(imm_i), .valid_o(valid_o),
        .ready_i(ready_i), .instr_o(instr_o), .err_o(err_o), .err_cnt_o(err_cnt_o)
    );

    instr_encoder #(.CHECK_RANGE(1'b0), .CNT_W(2)) dut_sat (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_s),
        .opcode_i(opcode_i), .rd_i(rd_i), .funct3_i(funct3_i), .rs1_i(rs1_i),
        .rs2_i(rs2_i), .funct7_i(funct7_i), .imm_i(imm_i), .valid_o(valid_s),
        .ready_i(ready_i), .instr_o(instr_s), .err_o(err_s), .err_cnt_o(err_cnt_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [6:0] f7,
                         input logic [31:0] imm);
        opcode_i = op; rd_i = rd; funct3_i = f3; rs1_i = rs1; rs2_i = rs2;
        funct7_i = f7; imm_i = imm;
    endtask

    // One isolated transaction with ready_i high; checks the 2-cycle latency.
    task automatic run_one(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [6:0] f7,
                           input logic [31:0] imm, output logic [31:0] wo,
                           output logic [31:0] wo_s, output logic eo, output logic eo_s);
        @(negedge clk_i);
        drive(op, rd, f3, rs1, rs2, f7, imm);
        valid_i = 1'b1;
        ready_i = 1'b1;
        #1 chk("accept_ready", 32'(ready_o), 32'd1);
        @(negedge clk_i);
        valid_i = 1'b0;
        chk("lat1_valid", 32'(valid_o), 32'd0);
        @(negedge clk_i);
        chk("lat2_valid", 32'(valid_o), 32'd1);
        wo = instr_o; wo_s = instr_s; eo = err_o; eo_s = err_s;
    endtask

    function automatic logic [31:0] dec_imm(input logic [31:0] x);
        logic [31:0] r;
        case (x[6:0])
            7'b0100011: r = {{20{x[31]}}, x[31:25], x[11:7]};
            7'b1100011: r = {{19{x[31]}}, x[31], x[7], x[30:25], x[11:8], 1'b0};
            7'b0110111: r = {{12{x[31]}}, x[31:12]};
            7'b1101111: r = {{11{x[31]}}, x[31], x[19:12], x[20], x[30:21], 1'b0};
            default:    r = {{20{x[31]}}, x[31:20]};
        endcase
        return r;
    endfunction

    initial begin
        rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        drive(7'd0, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
        #3;
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_instr", instr_o, 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_cnt", 32'(err_cnt_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        run_one(7'b0010011, 5'd1, 3'd0, 5'd2, 5'd0, 7'd0, 32'hFFFFFFFF, w, w_s, e, e_s);
        chk("addi_word", w, 32'hFFF10093);
        chk("addi_err", 32'(e), 32'd0);

        run_one(7'b1100011, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'd8, w, w_s, e, e_s);
        chk("beq8_word", w, 32'h00208463);
        chk("beq8_err", 32'(e), 32'd0);

        run_one(7'b1100011, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'd9, w, w_s, e, e_s);
        chk("beq9_word", w, 32'h00208463);
        chk("beq9_err", 32'(e), 32'd1);
        chk("beq9_err_nochk", 32'(e_s), 32'd0);
        @(negedge clk_i);
        chk("cnt_after_beq9", 32'(err_cnt_o), 32'd1);

        run_one(7'b1101111, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFFFFFC, w, w_s, e, e_s);
        chk("jal_m4_word", w, 32'hFFDFF06F);
        chk("jal_m4_err", 32'(e), 32'd0);

        run_one(7'b1101111, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'h00100000, w, w_s, e, e_s);
        chk("jal_big_word", w, 32'h8000006F);
        chk("jal_big_err", 32'(e), 32'd1);
        chk("jal_big_word_nochk", w_s, 32'h8000006F);
        chk("jal_big_err_nochk", 32'(e_s), 32'd0);
        @(negedge clk_i);
        chk("cnt_after_jal", 32'(err_cnt_o), 32'd2);

        run_one(7'b0010011, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2047, w, w_s, e, e_s);
        chk("addi_2047_word", w, 32'h7FF00013);
        chk("addi_2047_err", 32'(e), 32'd0);
        run_one(7'b0010011, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048, w, w_s, e, e_s);
        chk("addi_2048_word", w, 32'h80000013);
        chk("addi_2048_err", 32'(e), 32'd1);

        run_one(7'b0110111, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h00012345, w, w_s, e, e_s);
        chk("lui_word", w, 32'h123452B7);
        chk("lui_err", 32'(e), 32'd0);

        run_one(7'b0100011, 5'd0, 3'd2, 5'd2, 5'd3, 7'd0, 32'hFFFFFFFC, w, w_s, e, e_s);
        chk("sw_word", w, 32'hFE312E23);
        chk("sw_err", 32'(e), 32'd0);

        run_one(7'b0110011, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'hDEADBEEF, w, w_s, e, e_s);
        chk("add_word", w, 32'h002081B3);
        run_one(7'b0110011, 5'd3, 3'd0, 5'd1, 5'd2, 7'h20, 32'd0, w, w_s, e, e_s);
        chk("sub_word", w, 32'h402081B3);
        chk("sub_err", 32'(e), 32'd0);

        run_one(7'h7F, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0, w, w_s, e, e_s);
        chk("badop_word", w, 32'h002081FF);
        chk("badop_err", 32'(e), 32'd1);
        chk("badop_err_nochk", 32'(e_s), 32'd1);
        @(negedge clk_i);
        chk("cnt_after_badop", 32'(err_cnt_o), 32'd4);
        chk("cnt_sat_after_badop", 32'(err_cnt_s), 32'd1);

        // Round trip through an independent immediate decoder.
        for (int i = 0; i < 15; i++) begin
            logic [6:0]  op;
            logic [31:0] imm;
            int          v;
            case (i % 5)
                0: begin op = 7'b0010011; v = int'($urandom_range(0, 4095)) - 2048; end
                1: begin op = 7'b0100011; v = int'($urandom_range(0, 4095)) - 2048; end
                2: begin op = 7'b1100011; v = (int'($urandom_range(0, 4095)) - 2048) * 2; end
                3: begin op = 7'b1101111; v = (int'($urandom_range(0, 1048575)) - 524288) * 2; end
                default: begin op = 7'b0110111; v = int'($urandom_range(0, 1048575)) - 524288; end
            endcase
            imm = 32'(v);
            run_one(op, 5'(i), 3'd1, 5'd3, 5'd4, 7'd0, imm, w, w_s, e, e_s);
            chk("rt_imm", dec_imm(w), imm);
            chk("rt_op", 32'(w[6:0]), 32'(op));
            chk("rt_err", 32'(e), 32'd0);
        end

        // Back-pressure: four back-to-back words, ready_i low for three cycles.
        @(negedge clk_i);
        drive(7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd1);
        valid_i = 1'b1; ready_i = 1'b1;
        #1 chk("bp0_ready", 32'(ready_o), 32'd1);
        @(negedge clk_i);
        drive(7'b0010011, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2);
        ready_i = 1'b0;
        #1 chk("bp1_ready", 32'(ready_o), 32'd1);
        @(negedge clk_i);
        drive(7'b0010011, 5'd3, 3'd0, 5'd0, 5'd0, 7'd0, 32'd3);
        #1 chk("bp2_ready", 32'(ready_o), 32'd0);
        chk("bp2_ready_sat", 32'(ready_s), 32'd0);
        chk("bp2_valid", 32'(valid_o), 32'd1);
        chk("bp2_instr", instr_o, 32'h00100093);
        @(negedge clk_i);
        #1 chk("bp3_ready", 32'(ready_o), 32'd0);
        chk("bp3_instr_stable", instr_o, 32'h00100093);
        chk("bp3_valid_stable", 32'(valid_o), 32'd1);
        @(negedge clk_i);
        ready_i = 1'b1;
        #1 chk("bp4_ready", 32'(ready_o), 32'd1);
        chk("bp4_instr", instr_o, 32'h00100093);
        @(negedge clk_i);
        drive(7'b0010011, 5'd4, 3'd0, 5'd0, 5'd0, 7'd0, 32'd4);
        #1 chk("bp5_ready", 32'(ready_o), 32'd1);
        chk("bp5_instr", instr_o, 32'h00200113);
        @(negedge clk_i);
        valid_i = 1'b0;
        chk("bp6_instr", instr_o, 32'h00300193);
        @(negedge clk_i);
        chk("bp7_instr", instr_o, 32'h00400213);
        chk("bp7_valid", 32'(valid_o), 32'd1);
        @(negedge clk_i);
        chk("bp8_valid", 32'(valid_o), 32'd0);

        // Counter saturation on the 2-bit instance.
        for (int i = 0; i < 5; i++) begin
            run_one(7'h00, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0, w, w_s, e, e_s);
        end
        @(negedge clk_i);
        chk("cnt_sat", 32'(err_cnt_s), 32'd3);
        chk("cnt_main", 32'(err_cnt_o), 32'd9);

        // Asynchronous reset with a word in flight.
        drive(7'h00, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
        valid_i = 1'b1; ready_i = 1'b1;
        @(negedge clk_i);
        valid_i = 1'b0;
        @(negedge clk_i);
        chk("pre_rst_valid", 32'(valid_o), 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(valid_o), 32'd0);
        chk("mid_rst_valid_sat", 32'(valid_s), 32'd0);
        chk("mid_rst_instr", instr_o, 32'd0);
        chk("mid_rst_cnt", 32'(err_cnt_o), 32'd0);
        chk("mid_rst_cnt_sat", 32'(err_cnt_s), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("post_rst_valid", 32'(valid_o), 32'd0);
        chk("post_rst_cnt", 32'(err_cnt_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
